sensor_frame_packer: RTL

//  Sits between i2c_controller and uart_tx. Buffers 16-bit sensor samples and

---
 rtl/sensor_frame_packer_pkg.sv | 37 +++
 rtl/sensor_frame_packer_sample_fifo.sv | 64 ++++++
 rtl/sensor_frame_packer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sensor_frame_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sensor_frame_packer_pkg                                              |
// | Shared types, frame constants and helpers for the frame packer.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package sensor_frame_packer_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // SYNC, SEQ, MSB, LSB, CHK
  localparam int         FRAME_LEN       = 5;
  localparam logic [7:0] SYNC_DEFAULT    = 8'hAA;
  localparam int         TIMEOUT_DEFAULT = 24000;

  // Bits needed for a timer that counts 0 .. cycles-1
  function automatic int timer_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  localparam int TIMER_W = timer_width(TIMEOUT_DEFAULT);

  // Frame checksum: byte-wise sum of SEQ, MSB and LSB, modulo 256
  function automatic logic [7:0] frame_checksum(input logic [7:0] seq_b,
                                                input logic [7:0] msb_b,
                                                input logic [7:0] lsb_b);
    return seq_b + msb_b + lsb_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_frame_packer_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sensor_frame_packer_sample_fifo                                      |
// | Synchronous sample FIFO with combinational head read. A push into a  |
// | full FIFO is accepted when a pop happens in the same cycle.          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sensor_frame_packer_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign full    = (cnt == DEPTH_CNT);
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // The head slot is read before the edge, so a full FIFO can reuse it
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Sample storage; contents need no reset because the pointers gate reads
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sensor_frame_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sensor_frame_packer                                                  |
// | Buffers 16-bit sensor samples and serialises each into a 5-byte      |
// | frame (SYNC, SEQ, MSB, LSB, CHK) over a start/done byte handshake.   |
// | Counts dropped samples and frames aborted by a transmit timeout.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sensor_frame_packer
  import sensor_frame_packer_pkg::*;
#(
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sensor_data,
  input  logic        data_valid,
  output logic [7:0]  uart_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        frame_active,
  output logic [7:0]  overflow_cnt,
  output logic [7:0]  timeout_cnt
);

  localparam int            TW          = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX    = 3'(FRAME_LEN - 1);

  state_t        state;
  state_t        state_next;
  logic [15:0]   fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [7:0]    frame_q [FRAME_LEN];
  logic [2:0]    idx;
  logic [TW-1:0] timer;
  logic [7:0]    seq;
  logic          last_byte;
  logic          timer_expired;
  logic          sample_dropped;

  // The head sample is consumed exactly in the LOAD cycle
  assign pop            = (state == ST_LOAD);
  assign last_byte      = (idx == LAST_IDX);
  assign timer_expired  = (timer == TIMER_LIMIT);
  assign sample_dropped = data_valid && fifo_full && !pop;

  sensor_frame_packer_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_valid),
    .pop   (pop),
    .wdata (sensor_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; tx_done outside WAIT is deliberately ignored
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (!fifo_empty) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_SEND;
      ST_SEND: state_next = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          state_next = last_byte ? ST_IDLE : ST_SEND;
        end else if (timer_expired) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; byte held from SEND through WAIT
  always_comb begin
    tx_start     = (state == ST_SEND);
    frame_active = (state != ST_IDLE);
    uart_data    = 8'h00;
    if (state == ST_SEND || state == ST_WAIT) begin
      uart_data = frame_q[idx];
    end
  end

  // Frame bytes captured from the FIFO head during LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        frame_q[i] <= 8'h00;
      end
    end else if (state == ST_LOAD) begin
      frame_q[0] <= SYNC_BYTE;
      frame_q[1] <= seq;
      frame_q[2] <= fifo_rdata[15:8];
      frame_q[3] <= fifo_rdata[7:0];
      frame_q[4] <= frame_checksum(seq, fifo_rdata[15:8], fifo_rdata[7:0]);
    end
  end

  // Byte index and per-byte handshake timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      timer <= '0;
    end else begin
      case (state)
        ST_LOAD: idx <= '0;
        ST_SEND: timer <= '0;
        ST_WAIT: begin
          timer <= timer + 1'b1;
          if (tx_done && !last_byte) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sequence number advances only when a frame completes; aborts reuse it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq <= 8'h00;
    end else if (state == ST_WAIT && tx_done && last_byte) begin
      seq <= seq + 8'd1;
    end
  end

  // Saturating drop and abort counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_cnt <= 8'h00;
      timeout_cnt  <= 8'h00;
    end else begin
      if (sample_dropped && overflow_cnt != 8'hFF) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end
      if (state == ST_WAIT && !tx_done && timer_expired && timeout_cnt != 8'hFF) begin
        timeout_cnt <= timeout_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
